// File: rtl/envia_senal.sv
// UART 8N1 transmitter fed by a small power-of-two FIFO.
// Bytes written while a frame is on the line queue up and go out back to back, with no idle gap between frames.
module envia_senal #(
    parameter int ClkFrequency = 100000000,
    parameter int Baud         = 9600,
    parameter int FifoDepth    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD_ready,
    output logic       TxD_busy,
    output logic       TxD
);

    localparam int BitPeriod = ClkFrequency / Baud;
    localparam int CntW      = (BitPeriod > 1) ? $clog2(BitPeriod) : 1;
    localparam int PtrW      = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam logic [CntW-1:0] LastCnt   = CntW'(BitPeriod - 1);
    localparam logic [PtrW:0]   FullCount = (PtrW+1)'(FifoDepth);

    generate
        if ((ClkFrequency < 2 * Baud) || (FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : g_bad_params
            $error("envia_senal: need ClkFrequency >= 2*Baud and FifoDepth a power of 2, at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   baudCnt_q;
    logic [2:0]        bitIdx_q;
    logic [7:0]        shift_q;
    logic              txd_q;

    logic [7:0]        fifoMem_q [FifoDepth];
    logic [PtrW-1:0]   wrPtr_q, wrPtr_d;
    logic [PtrW-1:0]   rdPtr_q, rdPtr_d;
    logic [PtrW:0]     count_q, count_d;

    logic              fifoEmpty;
    logic              wrFire;
    logic              popFire;
    logic              bitEnd;

    assign fifoEmpty = (count_q == '0);
    assign TxD_ready = (count_q < FullCount);
    assign wrFire    = rst_n && TxD_start && TxD_ready;
    assign bitEnd    = (baudCnt_q == LastCnt);
    assign TxD       = txd_q;
    assign TxD_busy  = (state_q != IDLE) || !fifoEmpty;

    // A pop only happens where the FSM loads a new frame: straight from IDLE, or at the end of a stop bit.
    always_comb begin
        popFire = 1'b0;
        case (state_q)
            IDLE:    popFire = !fifoEmpty;
            STOP:    popFire = bitEnd && !fifoEmpty;
            default: popFire = 1'b0;
        endcase
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (wrFire) begin
            wrPtr_d = wrPtr_q + PtrW'(1);
        end
        if (popFire) begin
            rdPtr_d = rdPtr_q + PtrW'(1);
        end
        case ({wrFire, popFire})
            2'b10:   count_d = count_q + (PtrW+1)'(1);
            2'b01:   count_d = count_q - (PtrW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrFire) begin
            fifoMem_q[wrPtr_q] <= TxD_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            txd_q     <= 1'b1;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (popFire) begin
                        shift_q   <= fifoMem_q[rdPtr_q];
                        baudCnt_q <= '0;
                        txd_q     <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (bitEnd) begin
                        baudCnt_q <= '0;
                        bitIdx_q  <= '0;
                        txd_q     <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        state_q   <= DATA;
                    end else begin
                        baudCnt_q <= baudCnt_q + CntW'(1);
                    end
                end
                DATA: begin
                    if (bitEnd) begin
                        baudCnt_q <= '0;
                        if (bitIdx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                            txd_q    <= shift_q[0];
                            shift_q  <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + CntW'(1);
                    end
                end
                STOP: begin
                    if (bitEnd) begin
                        baudCnt_q <= '0;
                        if (popFire) begin
                            shift_q <= fifoMem_q[rdPtr_q];
                            txd_q   <= 1'b0;
                            state_q <= START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    txd_q     <= 1'b1;
                    baudCnt_q <= '0;
                    bitIdx_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_envia_senal.sv
// Bench for envia_senal: a frame-level model predicts the line every cycle, and a mid-bit receiver checks decoded bytes against a scoreboard.
module tb_envia_senal;

    localparam int ClkFrequency = 160;
    localparam int Baud         = 10;
    localparam int FifoDepth    = 4;
    localparam int BitPeriod    = ClkFrequency / Baud;
    localparam int FrameLen     = 10 * BitPeriod;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       TxD_start = 1'b0;
    logic [7:0] TxD_data  = 8'h00;
    logic       TxD_ready;
    logic       TxD_busy;
    logic       TxD;

    envia_senal #(
        .ClkFrequency(ClkFrequency),
        .Baud        (Baud),
        .FifoDepth   (FifoDepth)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .TxD_start(TxD_start),
        .TxD_data (TxD_data),
        .TxD_ready(TxD_ready),
        .TxD_busy (TxD_busy),
        .TxD      (TxD)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending bytes as a queue, the frame on the line as a byte plus a cycle position.
    logic [7:0] mQ[$];
    logic [7:0] sbQ[$];
    bit         mInFrame  = 1'b0;
    int         mPos      = 0;
    logic [7:0] mCur      = 8'h00;
    int         mAccepted = 0;
    bit         checkEn   = 1'b0;
    bit         rstEdge   = 1'b0;
    bit         mWrOk;

    always @(posedge clk) begin
        if (!rst_n) begin
            mQ.delete();
            sbQ.delete();
            mInFrame = 1'b0;
            mPos     = 0;
            rstEdge  = 1'b1;
            checkEn  = 1'b1;
        end else begin
            rstEdge = 1'b0;
            mWrOk   = TxD_start && (mQ.size() < FifoDepth);
            if (mInFrame && mPos < FrameLen - 1) begin
                mPos++;
            end else if (mQ.size() != 0) begin
                mCur     = mQ.pop_front();
                sbQ.push_back(mCur);
                mInFrame = 1'b1;
                mPos     = 0;
            end else begin
                mInFrame = 1'b0;
            end
            if (mWrOk) begin
                mQ.push_back(TxD_data);
                mAccepted++;
            end
        end
    end

    function automatic logic expTxd();
        int k;
        if (!mInFrame) return 1'b1;
        k = mPos / BitPeriod;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return mCur[k-1];
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("txd_line", 32'(TxD), 32'(expTxd()));
            checkOutput("ready", 32'(TxD_ready), 32'(mQ.size() < FifoDepth));
            checkOutput("busy", 32'(TxD_busy), 32'(mInFrame || mQ.size() != 0));
        end
    end

    // Receiver: syncs on the falling start edge and samples each bit in its middle.
    bit         rxActive = 1'b0;
    int         rxCnt    = 0;
    logic [7:0] rxShift  = 8'h00;
    int         rxFrames = 0;

    always @(negedge clk) begin
        if (rstEdge || !checkEn) begin
            rxActive = 1'b0;
        end else if (!rxActive) begin
            if (TxD === 1'b0) begin
                rxActive = 1'b1;
                rxCnt    = 0;
            end
        end else begin
            rxCnt++;
            if (rxCnt == BitPeriod / 2) begin
                checkOutput("rx_start", 32'(TxD), 32'd0);
            end else if (rxCnt > BitPeriod / 2 && rxCnt < 9 * BitPeriod && (rxCnt % BitPeriod) == BitPeriod / 2) begin
                rxShift = {TxD, rxShift[7:1]};
            end else if (rxCnt == 9 * BitPeriod + BitPeriod / 2) begin
                checkOutput("rx_stop", 32'(TxD), 32'd1);
                if (sbQ.size() != 0) begin
                    checkOutput("rx_byte", 32'(rxShift), 32'(sbQ.pop_front()));
                end else begin
                    checkOutput("rx_scoreboard", 32'(sbQ.size()), 32'd1);
                end
                rxFrames++;
                rxActive = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        TxD_start = 1'b1;
        TxD_data  = d;
        step(1);
        TxD_start = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while ((mInFrame || mQ.size() != 0) && n < limit) begin
            step(1);
            n++;
        end
        checkOutput("wait_idle", 32'(n < limit), 32'd1);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: time limit reached, got no end of test, expected end before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int base;

        rst_n = 1'b0;
        step(3);
        checkOutput("reset_txd", 32'(TxD), 32'd1);
        checkOutput("reset_busy", 32'(TxD_busy), 32'd0);
        checkOutput("reset_ready", 32'(TxD_ready), 32'd1);
        rst_n = 1'b1;
        step(2);

        applyStimulus(8'hA5);
        checkOutput("lat_before", 32'(TxD), 32'd1);
        checkOutput("lat_busy", 32'(TxD_busy), 32'd1);
        step(1);
        checkOutput("lat_start", 32'(TxD), 32'd0);
        waitIdle(2 * FrameLen);
        checkOutput("frames_a5", 32'(rxFrames), 32'd1);
        checkOutput("idle_busy", 32'(TxD_busy), 32'd0);

        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h55);
        waitIdle(4 * FrameLen);
        checkOutput("frames_b2b", 32'(rxFrames), 32'd4);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h10 + 8'(i));
        end
        checkOutput("burst_full", 32'(TxD_ready), 32'd0);
        applyStimulus(8'hEE);
        checkOutput("drop_full", 32'(TxD_ready), 32'd0);
        n = 0;
        while (!(mInFrame && mPos == FrameLen - 1) && n < 2 * FrameLen) begin
            step(1);
            n++;
        end
        checkOutput("wait_stop", 32'(n < 2 * FrameLen), 32'd1);
        checkOutput("full_at_stop", 32'(TxD_ready), 32'd0);
        TxD_start = 1'b1;
        TxD_data  = 8'h77;
        step(1);
        TxD_start = 1'b0;
        checkOutput("ready_after_pop", 32'(TxD_ready), 32'd1);
        waitIdle(6 * FrameLen);
        checkOutput("frames_burst", 32'(rxFrames), 32'd9);

        applyStimulus(8'h3C);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        n = 0;
        while (!(mInFrame && mCur == 8'h3C && mPos == 4 * BitPeriod + 6) && n < 2 * FrameLen) begin
            step(1);
            n++;
        end
        checkOutput("wait_bit3", 32'(n < 2 * FrameLen), 32'd1);
        rst_n     = 1'b0;
        TxD_start = 1'b1;
        TxD_data  = 8'h99;
        step(1);
        checkOutput("midrst_txd", 32'(TxD), 32'd1);
        checkOutput("midrst_busy", 32'(TxD_busy), 32'd0);
        checkOutput("midrst_ready", 32'(TxD_ready), 32'd1);
        rst_n     = 1'b1;
        TxD_start = 1'b0;
        step(2 * FrameLen);
        checkOutput("no_tx_after_rst", 32'(rxFrames), 32'd9);
        checkOutput("idle_after_rst", 32'(TxD), 32'd1);
        applyStimulus(8'h5A);
        checkOutput("rst_lat_before", 32'(TxD), 32'd1);
        step(1);
        checkOutput("rst_lat_start", 32'(TxD), 32'd0);
        waitIdle(2 * FrameLen);
        checkOutput("frames_after_rst", 32'(rxFrames), 32'd10);

        base = mAccepted;
        n    = 0;
        while (mAccepted - base < 256 && n < 60000) begin
            TxD_start = ($urandom_range(0, 3) == 0);
            TxD_data  = 8'($urandom);
            step(1);
            n++;
        end
        TxD_start = 1'b0;
        checkOutput("rand_accept", 32'(mAccepted - base), 32'd256);
        waitIdle(6 * FrameLen);
        checkOutput("frames_rand", 32'(rxFrames), 32'd266);
        checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
